// File: rtl/pipeline_mem_bridge_pkg.sv
// Shared encodings for the unified memory bridge: FSM states and transaction owner.
// Imported by the arbiter and by the bridge top.
package pipeline_mem_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

  function automatic owner_t other_owner(input owner_t o);
    return (o == OWN_I) ? OWN_D : OWN_I;
  endfunction

endpackage

// File: rtl/pipeline_mem_arb.sv
// Two-way arbiter between fetch and data ports.
// DPRIO != 0 gives dmem fixed priority; DPRIO == 0 alternates on conflict.
module pipeline_mem_arb
  import pipeline_mem_bridge_pkg::*;
#(
  parameter int DPRIO = 1
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   grant_en,
  input  logic   imem_req,
  input  logic   dmem_req,
  output logic   grant_valid,
  output owner_t grant_owner
);

  owner_t last_owner;

  always_comb begin
    grant_valid = grant_en & (imem_req | dmem_req);
    grant_owner = OWN_I;
    if (dmem_req && !imem_req) begin
      grant_owner = OWN_D;
    end else if (dmem_req && imem_req) begin
      grant_owner = (DPRIO != 0) ? OWN_D : other_owner(last_owner);
    end
  end

  // Starts as "imem granted last" so the first conflict goes to dmem.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_owner <= OWN_I;
    end else if (grant_valid) begin
      last_owner <= grant_owner;
    end
  end

endmodule

// File: rtl/pipeline_mem_bridge.sv
// Bridges the core's fetch and data ports onto one req/gnt/rvalid memory port,
// with per-port completion pulses, stall flags and an optional response timeout.
module pipeline_mem_bridge
  import pipeline_mem_bridge_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int DPRIO   = 1,
  parameter int TIMEOUT = 0,
  parameter int TO_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                imem_req,
  input  logic [ADDR_W-1:0]   imem_addr,
  output logic [DATA_W-1:0]   imem_rdata,
  output logic                imem_ready,
  output logic                imem_err,
  input  logic                dmem_req,
  input  logic [ADDR_W-1:0]   dmem_addr,
  input  logic [DATA_W-1:0]   dmem_wdata,
  input  logic                dmem_we,
  input  logic [DATA_W/8-1:0] dmem_be,
  output logic [DATA_W-1:0]   dmem_rdata,
  output logic                dmem_ready,
  output logic                dmem_err,
  output logic                istall,
  output logic                dstall,
  output logic                mem_req,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT > 0) ? TO_W'(TIMEOUT - 1) : '0;

  state_t          state;
  state_t          state_nxt;
  owner_t          owner;
  logic            err_q;
  logic [TO_W-1:0] to_cnt;
  logic            grant_valid;
  owner_t          grant_owner;
  logic            timed_out;
  logic            resp_done;

  pipeline_mem_arb #(
    .DPRIO(DPRIO)
  ) u_arb (
    .clk        (clk),
    .rst        (rst),
    .grant_en   (state == IDLE),
    .imem_req   (imem_req),
    .dmem_req   (dmem_req),
    .grant_valid(grant_valid),
    .grant_owner(grant_owner)
  );

  // to_cnt holds the number of WAIT cycles already completed, so the
  // TIMEOUT-th WAIT cycle without rvalid is the one that gives up.
  always_comb begin
    timed_out = (TIMEOUT > 0) && (state == WAIT) && !mem_rvalid && (to_cnt == TO_LAST);
    resp_done = (state == WAIT) && (mem_rvalid || timed_out);
    state_nxt = state;
    case (state)
      IDLE:    if (grant_valid) state_nxt = ISSUE;
      ISSUE:   if (mem_gnt) state_nxt = WAIT;
      WAIT:    if (resp_done) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      owner      <= OWN_I;
      err_q      <= 1'b0;
      to_cnt     <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_we     <= 1'b0;
      mem_be     <= '0;
      imem_rdata <= '0;
      dmem_rdata <= '0;
    end else begin
      state  <= state_nxt;
      to_cnt <= (state == WAIT && state_nxt == WAIT) ? to_cnt + 1'b1 : '0;

      if (state == IDLE && grant_valid) begin
        owner <= grant_owner;
        err_q <= 1'b0;
        if (grant_owner == OWN_D) begin
          mem_addr  <= dmem_addr;
          mem_wdata <= dmem_wdata;
          mem_we    <= dmem_we;
          mem_be    <= dmem_be;
        end else begin
          mem_addr  <= imem_addr;
          mem_wdata <= '0;
          mem_we    <= 1'b0;
          mem_be    <= '1;
        end
      end

      // A real response beats a timeout landing on the same cycle.
      if (resp_done) begin
        err_q <= !mem_rvalid;
        if (owner == OWN_D) begin
          dmem_rdata <= mem_rvalid ? mem_rdata : '0;
        end else begin
          imem_rdata <= mem_rvalid ? mem_rdata : '0;
        end
      end
    end
  end

  assign mem_req    = (state == ISSUE);
  assign imem_ready = (state == RESP) && (owner == OWN_I);
  assign dmem_ready = (state == RESP) && (owner == OWN_D);
  assign imem_err   = imem_ready & err_q;
  assign dmem_err   = dmem_ready & err_q;
  assign istall     = imem_req & ~imem_ready;
  assign dstall     = dmem_req & ~dmem_ready;

endmodule

// File: tb/tb_pipeline_mem_bridge.sv
// Directed bench for pipeline_mem_bridge: a fixed-priority and a round-robin
// instance share every input, so their FSM timing is identical and only arbitration differs.
module tb_pipeline_mem_bridge;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        dmem_req;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_we;
  logic [3:0]  dmem_be;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  logic [31:0] imem_rdata, dmem_rdata, mem_addr, mem_wdata;
  logic        imem_ready, imem_err, dmem_ready, dmem_err, istall, dstall, mem_req, mem_we;
  logic [3:0]  mem_be;

  logic [31:0] rr_imem_rdata, rr_dmem_rdata, rr_mem_addr, rr_mem_wdata;
  logic        rr_imem_ready, rr_imem_err, rr_dmem_ready, rr_dmem_err;
  logic        rr_istall, rr_dstall, rr_mem_req, rr_mem_we;
  logic [3:0]  rr_mem_be;

  int check_cnt = 0;
  int pass_cnt  = 0;
  int fail_cnt  = 0;

  pipeline_mem_bridge #(
    .ADDR_W(32), .DATA_W(32), .DPRIO(1), .TIMEOUT(16), .TO_W(8)
  ) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_ready(imem_ready), .imem_err(imem_err),
    .dmem_req(dmem_req), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_we(dmem_we), .dmem_be(dmem_be), .dmem_rdata(dmem_rdata),
    .dmem_ready(dmem_ready), .dmem_err(dmem_err),
    .istall(istall), .dstall(dstall),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_be(mem_be),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  pipeline_mem_bridge #(
    .ADDR_W(32), .DATA_W(32), .DPRIO(0), .TIMEOUT(16), .TO_W(8)
  ) dut_rr (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(rr_imem_rdata),
    .imem_ready(rr_imem_ready), .imem_err(rr_imem_err),
    .dmem_req(dmem_req), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_we(dmem_we), .dmem_be(dmem_be), .dmem_rdata(rr_dmem_rdata),
    .dmem_ready(rr_dmem_ready), .dmem_err(rr_dmem_err),
    .istall(rr_istall), .dstall(rr_dstall),
    .mem_req(rr_mem_req), .mem_addr(rr_mem_addr), .mem_wdata(rr_mem_wdata),
    .mem_we(rr_mem_we), .mem_be(rr_mem_be),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the active edge; checks happen on the falling edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    imem_req = 1'b0; imem_addr = '0;
    dmem_req = 1'b0; dmem_addr = '0; dmem_wdata = '0; dmem_we = 1'b0; dmem_be = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

    #12;
    check_output("reset mem_req", {31'b0, mem_req}, 32'd0);
    check_output("reset mem_be", {28'b0, mem_be}, 32'd0);
    check_output("reset mem_addr", mem_addr, 32'd0);
    check_output("reset readies", {30'b0, imem_ready, dmem_ready}, 32'd0);
    cyc();
    rst = 1'b1;

    $display("[TB] read latency");
    imem_req = 1'b1; imem_addr = 32'h100; mem_gnt = 1'b1;
    @(negedge clk);
    check_output("rd c0 istall", {31'b0, istall}, 32'd1);
    check_output("rd c0 ready", {31'b0, imem_ready}, 32'd0);
    cyc();
    @(negedge clk);
    check_output("rd c1 mem_req", {31'b0, mem_req}, 32'd1);
    check_output("rd c1 mem_addr", mem_addr, 32'h100);
    check_output("rd c1 mem_be", {28'b0, mem_be}, 32'hF);
    check_output("rd c1 ready", {31'b0, imem_ready}, 32'd0);
    cyc();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hE3A00001;
    @(negedge clk);
    check_output("rd c2 istall", {31'b0, istall}, 32'd1);
    check_output("rd c2 mem_req", {31'b0, mem_req}, 32'd0);
    cyc();
    mem_rvalid = 1'b0; mem_rdata = '0;
    @(negedge clk);
    check_output("rd c3 ready", {31'b0, imem_ready}, 32'd1);
    check_output("rd c3 istall", {31'b0, istall}, 32'd0);
    check_output("rd c3 rdata", imem_rdata, 32'hE3A00001);
    check_output("rd c3 err", {31'b0, imem_err}, 32'd0);
    check_output("rd c3 dmem_ready", {31'b0, dmem_ready}, 32'd0);
    cyc();
    imem_req = 1'b0;
    @(negedge clk);
    check_output("rd c4 ready", {31'b0, imem_ready}, 32'd0);
    cyc();

    $display("[TB] fixed priority");
    imem_req = 1'b1; imem_addr = 32'h104;
    dmem_req = 1'b1; dmem_addr = 32'h2000; dmem_we = 1'b0; dmem_be = 4'hF;
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h55AA0000;
    cyc();
    @(negedge clk);
    check_output("fp c1 mem_addr", mem_addr, 32'h2000);
    cyc();
    cyc();
    @(negedge clk);
    check_output("fp c3 dmem_ready", {31'b0, dmem_ready}, 32'd1);
    check_output("fp c3 imem_ready", {31'b0, imem_ready}, 32'd0);
    check_output("fp c3 istall", {31'b0, istall}, 32'd1);
    check_output("fp c3 dmem_rdata", dmem_rdata, 32'h55AA0000);
    cyc();
    dmem_req = 1'b0;
    for (int c = 4; c <= 7; c++) begin
      @(negedge clk);
      check_output($sformatf("fp c%0d imem_ready", c), {31'b0, imem_ready}, {31'b0, c == 7});
      if (c == 5) check_output("fp c5 mem_addr", mem_addr, 32'h104);
      cyc();
    end
    imem_req = 1'b0;

    $display("[TB] round robin");
    imem_req = 1'b1; imem_addr = 32'h400;
    dmem_req = 1'b1; dmem_addr = 32'h800;
    mem_rdata = 32'h0BADC0DE;
    for (int t = 0; t < 6; t++) begin
      cyc();
      @(negedge clk);
      check_output($sformatf("rr t%0d mem_addr", t), rr_mem_addr, (t % 2 == 0) ? 32'h800 : 32'h400);
      check_output($sformatf("rr t%0d fixed addr", t), mem_addr, 32'h800);
      cyc();
      cyc();
      @(negedge clk);
      check_output($sformatf("rr t%0d dready", t), {31'b0, rr_dmem_ready}, {31'b0, t % 2 == 0});
      check_output($sformatf("rr t%0d iready", t), {31'b0, rr_imem_ready}, {31'b0, t % 2 == 1});
      cyc();
    end
    imem_req = 1'b0; dmem_req = 1'b0;

    $display("[TB] write with wait states");
    dmem_addr = 32'h3004; dmem_wdata = 32'hDEADBEEF; dmem_we = 1'b1; dmem_be = 4'b0011;
    mem_rdata = 32'h00000ACC;
    for (int c = 0; c <= 10; c++) begin
      dmem_req = 1'b1;
      mem_gnt = (c == 4);
      mem_rvalid = (c == 9);
      @(negedge clk);
      if (c >= 1 && c <= 4) begin
        check_output($sformatf("wr c%0d mem_req", c), {31'b0, mem_req}, 32'd1);
        check_output($sformatf("wr c%0d addr", c), mem_addr, 32'h3004);
        check_output($sformatf("wr c%0d wdata", c), mem_wdata, 32'hDEADBEEF);
        check_output($sformatf("wr c%0d be", c), {28'b0, mem_be}, 32'h3);
        check_output($sformatf("wr c%0d we", c), {31'b0, mem_we}, 32'd1);
      end
      if (c >= 5 && c <= 9) begin
        check_output($sformatf("wr c%0d ready", c), {31'b0, dmem_ready}, 32'd0);
      end
      if (c == 10) begin
        check_output("wr c10 ready", {31'b0, dmem_ready}, 32'd1);
        check_output("wr c10 err", {31'b0, dmem_err}, 32'd0);
      end
      cyc();
    end
    dmem_req = 1'b0; dmem_we = 1'b0; dmem_be = 4'hF; mem_rvalid = 1'b0; mem_gnt = 1'b0;

    $display("[TB] timeout");
    dmem_req = 1'b1; dmem_addr = 32'h5000; mem_gnt = 1'b1; mem_rdata = 32'hFFFF0000;
    for (int c = 0; c <= 18; c++) begin
      @(negedge clk);
      if (c == 17) check_output("to c17 ready", {31'b0, dmem_ready}, 32'd0);
      if (c == 18) begin
        check_output("to c18 ready", {31'b0, dmem_ready}, 32'd1);
        check_output("to c18 err", {31'b0, dmem_err}, 32'd1);
        check_output("to c18 rdata", dmem_rdata, 32'd0);
      end
      cyc();
    end
    dmem_addr = 32'h5004;
    cyc();
    cyc();
    mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
    cyc();
    mem_rvalid = 1'b0;
    @(negedge clk);
    check_output("to next ready", {31'b0, dmem_ready}, 32'd1);
    check_output("to next err", {31'b0, dmem_err}, 32'd0);
    check_output("to next rdata", dmem_rdata, 32'h12345678);
    cyc();
    dmem_req = 1'b0;
    cyc();

    $display("[TB] async reset");
    imem_req = 1'b1; imem_addr = 32'h600; mem_gnt = 1'b1; mem_rvalid = 1'b0;
    cyc();
    cyc();
    #2;
    rst = 1'b0; imem_req = 1'b0;
    #1;
    check_output("ar mem_req", {31'b0, mem_req}, 32'd0);
    check_output("ar mem_be", {28'b0, mem_be}, 32'd0);
    check_output("ar mem_addr", mem_addr, 32'd0);
    check_output("ar ready err", {28'b0, imem_ready, imem_err, dmem_ready, dmem_err}, 32'd0);
    check_output("ar imem_rdata", imem_rdata, 32'd0);
    cyc();
    rst = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'h77777777;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check_output($sformatf("ar stray%0d ready", c), {30'b0, imem_ready, dmem_ready}, 32'd0);
      cyc();
    end
    mem_rvalid = 1'b0;
    imem_req = 1'b1; imem_addr = 32'h700;
    cyc();
    cyc();
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    check_output("ar c2 ready", {31'b0, imem_ready}, 32'd0);
    cyc();
    mem_rvalid = 1'b0;
    @(negedge clk);
    check_output("ar c3 ready", {31'b0, imem_ready}, 32'd1);
    check_output("ar c3 rdata", imem_rdata, 32'hCAFEF00D);
    cyc();
    imem_req = 1'b0;
    cyc();

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
